regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: four read ports, two write ports, PC alias at the top
// index, and a post-reset clear sequence that zeroes every stored entry.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int AW     = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [WIDTH-1:0] r15,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  input  logic [AW-1:0]    rs,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic [WIDTH-1:0] rsv,
  output logic             busy
);

  localparam int NREGS = 2**AW;
  localparam logic [AW-1:0] PC   = AW'(NREGS - 1);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 2);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] mem [NREGS-1];
  logic             w3ok;
  logic             w4ok;
  logic [AW-1:0]    raddr [4];
  logic [WIDTH-1:0] rdata [4];

  // Port 4 loses to port 3 on an address collision, so its data never lands there.
  assign w3ok = (state == READY) && we3 && (wa3 != PC);
  assign w4ok = (state == READY) && we4 && (wa4 != PC) && !(we3 && (wa3 == wa4));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      idx <= idx + 1'b1;
      if (idx == LAST) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else begin
        if (w3ok) mem[wa3] <= wd3;
        if (w4ok) mem[wa4] <= wd4;
      end
    end
  end

  assign raddr[0] = ra1;
  assign raddr[1] = ra2;
  assign raddr[2] = ra3;
  assign raddr[3] = rs;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = '0;
      if (raddr[i] == PC) begin
        rdata[i] = r15;
      end else if (state == READY) begin
        if (BYPASS && w3ok && (wa3 == raddr[i]))
          rdata[i] = wd3;
        else if (BYPASS && w4ok && (wa4 == raddr[i]))
          rdata[i] = wd4;
        else
          rdata[i] = mem[raddr[i]];
      end
    end
  end

  assign rd1 = rdata[0];
  assign rd2 = rdata[1];
  assign rd3 = rdata[2];
  assign rsv = rdata[3];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values, a negedge
// monitor pops and compares them against the selected output.
module tb_regfile_mp;

  localparam int WIDTH  = 32;
  localparam int AW     = 4;
  localparam bit BYPASS = 1'b1;

  localparam int SEL_RD1  = 0;
  localparam int SEL_RD2  = 1;
  localparam int SEL_RD3  = 2;
  localparam int SEL_RSV  = 3;
  localparam int SEL_BUSY = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             we3, we4;
  logic [AW-1:0]    wa3, wa4;
  logic [WIDTH-1:0] wd3, wd4;
  logic [WIDTH-1:0] r15;
  logic [AW-1:0]    ra1, ra2, ra3, rs;
  logic [WIDTH-1:0] rd1, rd2, rd3, rsv;
  logic             busy;

  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t        expQ [$];
  string       nameQ [$];
  int          checks   = 0;
  int          failures = 0;
  logic [WIDTH-1:0] model [15];

  regfile_mp #(.WIDTH(WIDTH), .AW(AW), .BYPASS(BYPASS)) dut (
    .clk(clk), .reset(reset),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .r15(r15),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .rs(rs),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .rsv(rsv),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w3, input logic [AW-1:0] a3, input logic [WIDTH-1:0] d3,
                               input logic w4, input logic [AW-1:0] a4, input logic [WIDTH-1:0] d4,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic [AW-1:0] r3, input logic [AW-1:0] rsa);
    we3 = w3; wa3 = a3; wd3 = d3;
    we4 = w4; wa4 = a4; wd4 = d4;
    ra1 = r1; ra2 = r2; ra3 = r3; rs = rsa;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [WIDTH-1:0] val);
    exp_t e;
    e.sel = 3'(sel);
    e.val = val;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: the outputs are combinational/registered, so every queued
  // expectation is due at the negedge of the cycle it was issued in.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        exp_t e;
        string n;
        logic [WIDTH-1:0] act;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        case (e.sel)
          3'd0:    act = rd1;
          3'd1:    act = rd2;
          3'd2:    act = rd3;
          3'd3:    act = rsv;
          default: act = {{(WIDTH-1){1'b0}}, busy};
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("[TB] FAIL %s: got %h expected %h", n, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 15; i++) model[i] = '0;
    r15   = 32'h0000_0108;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("busy_after_reset_edge", SEL_BUSY, 1);
    reset = 1'b0;

    // Partial clear, then reset again at clear cycle 7.
    for (int c = 0; c < 7; c++) begin
      checkOutput("busy_first_clear", SEL_BUSY, 1);
      step();
    end
    reset = 1'b1;
    checkOutput("busy_reassert", SEL_BUSY, 1);
    step();
    checkOutput("busy_reset_held", SEL_BUSY, 1);
    reset = 1'b0;

    // Full clear; writes to entry 2 attempted throughout must be ignored.
    for (int c = 0; c < 15; c++) begin
      applyStimulus(1, 2, 32'h5555_5555, 1, 4, 32'h6666_6666, 2, 15, 4, 0);
      checkOutput("busy_clear", SEL_BUSY, 1);
      checkOutput("clear_read_zero", SEL_RD1, 0);
      checkOutput("clear_read_pc", SEL_RD2, 32'h0000_0108);
      checkOutput("clear_no_bypass", SEL_RD3, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_low_after_clear", SEL_BUSY, 0);
    step();

    for (int a = 0; a < 15; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 4'(a), 15, 4'(a), 4'(a));
      checkOutput("post_clear_zero", SEL_RD1, 0);
      checkOutput("post_clear_pc", SEL_RD2, 32'h0000_0108);
      checkOutput("post_clear_rsv_zero", SEL_RSV, 0);
      step();
    end

    // Same-cycle write/read bypass, then registered value.
    applyStimulus(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 3, 3, 0, 0);
    checkOutput("bypass_rd1", SEL_RD1, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    checkOutput("bypass_rd2", SEL_RD2, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    step();
    model[3] = 32'hDEAD_BEEF;
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
    checkOutput("stored_rd1", SEL_RD1, 32'hDEAD_BEEF);
    checkOutput("stored_rd2", SEL_RD2, 32'hDEAD_BEEF);
    checkOutput("stored_rd3", SEL_RD3, 32'hDEAD_BEEF);
    checkOutput("stored_rsv", SEL_RSV, 32'hDEAD_BEEF);
    step();

    // Write-port collision: port 3 wins.
    applyStimulus(1, 5, 32'h11, 1, 5, 32'h22, 5, 0, 0, 0);
    checkOutput("collide_bypass", SEL_RD1, BYPASS ? 32'h11 : 32'h0);
    step();
    model[5] = 32'h11;
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    checkOutput("collide_stored", SEL_RD1, 32'h11);
    step();

    // Both ports to different entries on the same edge.
    applyStimulus(1, 7, 32'h33, 1, 6, 32'h22, 0, 6, 7, 0);
    checkOutput("dual_bypass_p4", SEL_RD2, BYPASS ? 32'h22 : 32'h0);
    checkOutput("dual_bypass_p3", SEL_RD3, BYPASS ? 32'h33 : 32'h0);
    step();
    model[6] = 32'h22;
    model[7] = 32'h33;
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 5, 0, 7);
    checkOutput("dual_stored_p4", SEL_RD1, 32'h22);
    checkOutput("dual_stored_p3", SEL_RSV, 32'h33);
    checkOutput("collide_kept", SEL_RD2, 32'h11);
    step();

    // Writes to the PC index are discarded; reads keep tracking r15.
    applyStimulus(1, 15, 32'h1234, 1, 15, 32'h5678, 15, 0, 0, 0);
    checkOutput("pc_write_bypass", SEL_RD1, 32'h0000_0108);
    step();
    r15 = 32'h0000_0200;
    applyStimulus(0, 0, 0, 0, 0, 0, 15, 15, 15, 15);
    checkOutput("pc_track_rd1", SEL_RD1, 32'h0000_0200);
    checkOutput("pc_track_rsv", SEL_RSV, 32'h0000_0200);
    step();
    for (int a = 0; a < 15; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 4'(a), 4'(14 - a), 0, 0);
      checkOutput("final_scan_rd1", SEL_RD1, model[a]);
      checkOutput("final_scan_rd2", SEL_RD2, model[14 - a]);
      step();
    end

    for (int k = 0; k < 10 && expQ.size() > 0; k++) step();
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
